axis_rr_pkt_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI4-Stream output between S_COUNT AXI4-Stream sources. A source holds the grant from its first beat through the beat carrying tlast, so packets are never interleaved. The output passes through an internal skid-buffer stage, so the arbiter can sit in front of any downstream consumer without a combinational valid/ready path.

---
 rtl/axis_rr_pkt_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/axis_rr_pkt_arbiter.sv
// axis_rr_pkt_arbiter: packet-level round-robin AXIS arbiter feeding a registered skid output stage
module axis_rr_pkt_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH+7)/8,
  parameter int USER_WIDTH = 1,
  parameter int SEL_WIDTH  = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [S_COUNT-1:0]            src_enable,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [SEL_WIDTH-1:0]          m_axis_tid,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_idx
);
  localparam int PW = SEL_WIDTH + USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] last_q, grant_idx_q, win, j;
  logic [S_COUNT-1:0] req;
  logic beat_in, beat_last, in_ready_q, in_ready_d, out_valid_q, tmp_valid_q;
  logic [PW-1:0] in_pkt, out_q, tmp_q;
  assign req = s_axis_tvalid & src_enable;
  assign beat_last = s_axis_tlast[grant_idx_q];
  assign in_pkt = {grant_idx_q,
                   s_axis_tuser[grant_idx_q*USER_WIDTH +: USER_WIDTH],
                   beat_last,
                   s_axis_tkeep[grant_idx_q*KEEP_WIDTH +: KEEP_WIDTH],
                   s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH]};
  // scan downward so the closest requester after last_q overwrites the others
  always_comb begin
    win = last_q;
    j = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      j = SEL_WIDTH'((int'(last_q) + k) % S_COUNT);
      if (req[j]) win = j;
    end
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (|req ? ACTIVE : IDLE) : (beat_in && beat_last ? IDLE : ACTIVE);
  end
  always_comb begin
    s_axis_tready = '0;
    s_axis_tready[grant_idx_q] = state_q == ACTIVE && in_ready_q;
    beat_in = state_q == ACTIVE && in_ready_q && s_axis_tvalid[grant_idx_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SEL_WIDTH'(S_COUNT-1);
      grant_idx_q <= '0;
    end else begin
      if (state_q == IDLE && |req) grant_idx_q <= win;
      if (beat_in && beat_last) last_q <= grant_idx_q;
    end
  end
  // ready is registered; temp catches the one beat in flight when downstream stalls
  assign in_ready_d = m_axis_tready | (!tmp_valid_q & (!out_valid_q | !beat_in));
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      tmp_valid_q <= 1'b0;
      out_q <= '0;
      tmp_q <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      if (in_ready_q) begin
        if (m_axis_tready || !out_valid_q) begin
          out_valid_q <= beat_in;
          if (beat_in) out_q <= in_pkt;
        end else begin
          tmp_valid_q <= beat_in;
          if (beat_in) tmp_q <= in_pkt;
        end
      end else if (m_axis_tready) begin
        out_valid_q <= tmp_valid_q;
        out_q <= tmp_q;
        tmp_valid_q <= 1'b0;
      end
    end
  end
  assign {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_q;
  assign m_axis_tvalid = out_valid_q;
  assign grant_valid = state_q == ACTIVE;
  assign grant_idx = grant_idx_q;
endmodule
